// File: rtl/btn_cond_pkg.sv
// Shared encodings and default constants for the button pulse conditioner.
// BTN_HOLD_REPEAT_EN adds the default auto-repeat period.
package btn_cond_pkg;

  // Per-channel debounce states. Bit 1 of the encoding is the debounced level.
  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CNT_HI    = 2'd1,
    STABLE_HI = 2'd2,
    CNT_LO    = 2'd3
  } db_state_t;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 500000;
  localparam int CNT_W_DEF           = 19;
`ifdef BTN_HOLD_REPEAT_EN
  localparam int REPEAT_CYCLES_DEF   = 25000000;
`endif

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: synchroniser, debounce counter FSM and press (rise) detect.
// With BTN_HOLD_REPEAT_EN a held level also emits a rise every REPEAT_CYCLES.
module btn_debounce_ch
  import btn_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
`ifdef BTN_HOLD_REPEAT_EN
  ,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  db_state_t              state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   press;
  logic                   level_nxt;

  // Synchroniser chain; s is the last stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync <= '0;
    else        sync <= {sync[SYNC_STAGES-2:0], raw};
  end

  assign s = sync[SYNC_STAGES-1];

  // Debounce state and count registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= STABLE_LO;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: count while s differs from the level, restart on any bounce,
  // accept the new level when the count reaches DEBOUNCE_CYCLES-1.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    press     = 1'b0;
    case (state)
      STABLE_LO: if (s) begin
        state_nxt = CNT_HI;
        cnt_nxt   = CNT_ONE;
      end
      CNT_HI: begin
        if (!s) state_nxt = STABLE_LO;
        else if (cnt == CNT_LAST) begin
          state_nxt = STABLE_HI;
          press     = 1'b1;
        end else cnt_nxt = cnt + CNT_ONE;
      end
      STABLE_HI: if (!s) begin
        state_nxt = CNT_LO;
        cnt_nxt   = CNT_ONE;
      end
      CNT_LO: begin
        if (s) state_nxt = STABLE_HI;
        else if (cnt == CNT_LAST) state_nxt = STABLE_LO;
        else cnt_nxt = cnt + CNT_ONE;
      end
      default: state_nxt = STABLE_LO;
    endcase
  end

  assign level     = (state == STABLE_HI) || (state == CNT_LO);
  assign level_nxt = (state_nxt == STABLE_HI) || (state_nxt == CNT_LO);

`ifdef BTN_HOLD_REPEAT_EN
  localparam int             REP_W    = $clog2(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] rep_cnt;
  logic             rep_hit;

  // Repeat timer runs only while the level is held high; a level that is
  // dropping this edge does not get a final repeat.
  assign rep_hit = level && level_nxt && (rep_cnt == REP_LAST);

  // Repeat period counter, cleared whenever the level is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 rep_cnt <= '0;
    else if (!level)            rep_cnt <= '0;
    else if (rep_cnt == REP_LAST) rep_cnt <= '0;
    else                        rep_cnt <= rep_cnt + REP_W'(1);
  end

  assign rise = press | rep_hit;
`else
  assign rise = press;
`endif

  // level_nxt only feeds the repeat gate; keep it referenced in the plain build.
  logic unused_ok;
  assign unused_ok = level_nxt;

endmodule

// File: rtl/button_pulse_conditioner.sv
// Two debounced pushbuttons to one-cycle P0/P1 pulses for the sequence
// detector; simultaneous presses are dropped and flagged on conflict.
// Optional auto-repeat on held buttons: define BTN_HOLD_REPEAT_EN.
module button_pulse_conditioner
  import btn_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
`ifdef BTN_HOLD_REPEAT_EN
  ,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic btn0_raw,
  input  logic btn1_raw,
  output logic p0,
  output logic p1,
  output logic btn0_level,
  output logic btn1_level,
  output logic conflict
);

  localparam int NUM_CH = 2;

  logic [NUM_CH-1:0] raw, level, rise;

  assign raw = {btn1_raw, btn0_raw};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    btn_debounce_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
`ifdef BTN_HOLD_REPEAT_EN
      ,
      .REPEAT_CYCLES  (REPEAT_CYCLES)
`endif
    ) u_ch (
      .clk  (clk),
      .reset(reset),
      .raw  (raw[i]),
      .level(level[i]),
      .rise (rise[i])
    );
  end

  assign btn0_level = level[0];
  assign btn1_level = level[1];

  // Registered arbitration: a same-cycle pair of rises is ambiguous, so it
  // becomes a conflict flag instead of two pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p0       <= 1'b0;
      p1       <= 1'b0;
      conflict <= 1'b0;
    end else begin
      p0       <= rise[0] & ~rise[1];
      p1       <= rise[1] & ~rise[0];
      conflict <= rise[0] & rise[1];
    end
  end

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Directed bench for button_pulse_conditioner with SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4. Raw inputs change on the falling edge; outputs are
// sampled 1 ns after each rising edge. Edge 1 is the first rising edge
// after a change.
module tb_button_pulse_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int CW   = 3;
`ifdef BTN_HOLD_REPEAT_EN
  localparam int REP  = 8;
  localparam int HOLD = 8;
`else
  localparam int HOLD = 10;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn0_raw = 1'b0;
  logic btn1_raw = 1'b0;
  logic p0, p1, btn0_level, btn1_level, conflict;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  button_pulse_conditioner #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (CW)
`ifdef BTN_HOLD_REPEAT_EN
    ,
    .REPEAT_CYCLES  (REP)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn0_raw  (btn0_raw),
    .btn1_raw  (btn1_raw),
    .p0        (p0),
    .p1        (p1),
    .btn0_level(btn0_level),
    .btn1_level(btn1_level),
    .conflict  (conflict)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", tag, obs, exp);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " p0"}, p0, 1'b0);
    chk({tag, " p1"}, p1, 1'b0);
    chk({tag, " conflict"}, conflict, 1'b0);
    chk({tag, " lvl0"}, btn0_level, 1'b0);
    chk({tag, " lvl1"}, btn1_level, 1'b0);
  endtask

  // Step n edges. eX = edge of the single expected pulse (0 = none).
  // lX = edge where level X takes value vX (0 = level is vX throughout).
  task automatic run(input string name, input int n, input int e0, input int e1,
                     input int ec, input int l0, input int l1,
                     input logic v0, input logic v1);
    logic x0, x1;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      x0 = (l0 == 0 || k >= l0) ? v0 : ~v0;
      x1 = (l1 == 0 || k >= l1) ? v1 : ~v1;
      chk($sformatf("%s e%0d p0", name, k), p0, k == e0);
      chk($sformatf("%s e%0d p1", name, k), p1, k == e1);
      chk($sformatf("%s e%0d conflict", name, k), conflict, k == ec);
      chk($sformatf("%s e%0d lvl0", name, k), btn0_level, x0);
      chk($sformatf("%s e%0d lvl1", name, k), btn1_level, x1);
    end
  endtask

  initial begin
    logic [5:0] pat;

    // reset state, held across clock edges
    #1;
    chk_all_zero("rst t0");
    @(posedge clk); #1;
    chk_all_zero("rst held");
    @(negedge clk) reset = 1'b1;
    run("idle", 3, 0, 0, 0, 0, 0, 1'b0, 1'b0);

    // 1: reset pulsed mid-count; the partial count must be discarded
    @(negedge clk) btn0_raw = 1'b1;
    run("t1 pre", 4, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1 chk_all_zero("t1 async");
    @(negedge clk) reset = 1'b1;
    run("t1 fresh", HOLD, 6, 0, 0, 6, 0, 1'b1, 1'b0);

    // 6: release, level drops on edge 6, no pulse
    @(negedge clk) btn0_raw = 1'b0;
    run("t6 rel", 10, 0, 0, 0, 6, 0, 1'b0, 1'b0);

    // 2: clean press
    @(negedge clk) btn0_raw = 1'b1;
    run("t2 press", HOLD, 6, 0, 0, 6, 0, 1'b1, 1'b0);

    // reset with the level high clears it without waiting for a clock
    #2 reset = 1'b0;
    #1 chk("t1 async lvl0", btn0_level, 1'b0);
    @(negedge clk) reset = 1'b1;
    run("t1 repress", HOLD, 6, 0, 0, 6, 0, 1'b1, 1'b0);
    @(negedge clk) btn0_raw = 1'b0;
    run("t6 rel2", 10, 0, 0, 0, 6, 0, 1'b0, 1'b0);

    // 3: bouncing input never reaches 4 stable cycles
    pat = 6'b110110;
    for (int i = 5; i >= 0; i--) begin
      @(negedge clk) btn0_raw = pat[i];
      @(posedge clk); #1;
      chk($sformatf("t3 bounce %0d p0", i), p0, 1'b0);
      chk($sformatf("t3 bounce %0d lvl0", i), btn0_level, 1'b0);
    end
    run("t3 tail", 8, 0, 0, 0, 0, 0, 1'b0, 1'b0);

    // 4: simultaneous press -> conflict, no pulses, both levels set
    @(negedge clk) begin
      btn0_raw = 1'b1;
      btn1_raw = 1'b1;
    end
    run("t4 both", HOLD, 0, 0, 6, 6, 6, 1'b1, 1'b1);
    @(negedge clk) begin
      btn0_raw = 1'b0;
      btn1_raw = 1'b0;
    end
    run("t4 rel", 10, 0, 0, 0, 6, 6, 1'b0, 1'b0);

    // 5: btn1 one cycle after btn0 -> separate pulses, no conflict
    @(negedge clk) btn0_raw = 1'b1;
    @(posedge clk); #1;
    chk("t5 e1 p0", p0, 1'b0);
    chk("t5 e1 p1", p1, 1'b0);
    chk("t5 e1 conflict", conflict, 1'b0);
    @(negedge clk) btn1_raw = 1'b1;
    run("t5 stag", HOLD - 1, 5, 6, 0, 5, 6, 1'b1, 1'b1);
    @(negedge clk) begin
      btn0_raw = 1'b0;
      btn1_raw = 1'b0;
    end
    run("t5 rel", 10, 0, 0, 0, 6, 6, 1'b0, 1'b0);

`ifdef BTN_HOLD_REPEAT_EN
    // 7: held button repeats every REP cycles after the first pulse
    @(negedge clk) btn0_raw = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      chk($sformatf("t7 e%0d p0", k), p0, (k >= 6) && ((k - 6) % REP == 0));
      chk($sformatf("t7 e%0d p1", k), p1, 1'b0);
      chk($sformatf("t7 e%0d conflict", k), conflict, 1'b0);
    end
    @(negedge clk) btn0_raw = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      chk($sformatf("t7 rel e%0d lvl0", k), btn0_level, k < 6);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
